// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with level flags, sticky errors and FWFT mode
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_en,
    input  logic                     read_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == C_DEPTH);
    // A read that frees a slot lets a write into a full FIFO in the same cycle
    assign w_rd_acc = read_en & ~w_empty;
    assign w_wr_acc = write_en & (~w_full | w_rd_acc);

    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= r_mem[r_rd_ptr];
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - 1'b1;
            end
            if (write_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (read_en && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; zero while empty so reset reads back as 0
            assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_std
            assign data_out = r_data_out;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AFULL);
    assign almost_empty = (r_count <= C_AEMPTY);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param, standard and FWFT instances
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_en = 1'b0;
    logic       read_en = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] d0_data_out, d1_data_out;
    logic       d0_full, d0_empty, d0_afull, d0_aempty, d0_ovf, d0_udf;
    logic       d1_full, d1_empty, d1_afull, d1_aempty, d1_ovf, d1_udf;
    logic [4:0] d0_count, d1_count;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q[$];
    int         m_count = 0;
    bit         m_ovf = 0;
    bit         m_udf = 0;
    logic [7:0] m_dout = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .data_in(data_in),
        .data_out(d0_data_out), .full(d0_full), .empty(d0_empty), .almost_full(d0_afull),
        .almost_empty(d0_aempty), .count(d0_count), .overflow(d0_ovf), .underflow(d0_udf)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .data_in(data_in),
        .data_out(d1_data_out), .full(d1_full), .empty(d1_empty), .almost_full(d1_afull),
        .almost_empty(d1_aempty), .count(d1_count), .overflow(d1_ovf), .underflow(d1_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count",        32'(d0_count), 32'(m_count));
        chk("full",         32'(d0_full),  32'(m_count == 16));
        chk("empty",        32'(d0_empty), 32'(m_count == 0));
        chk("almost_full",  32'(d0_afull), 32'(m_count >= 14));
        chk("almost_empty", 32'(d0_aempty), 32'(m_count <= 2));
        chk("overflow",     32'(d0_ovf),   32'(m_ovf));
        chk("underflow",    32'(d0_udf),   32'(m_udf));
        chk("data_out",     32'(d0_data_out), 32'(m_dout));
        chk("fwft_count",   32'(d1_count), 32'(m_count));
        chk("fwft_empty",   32'(d1_empty), 32'(m_count == 0));
        if (m_count > 0) begin
            chk("fwft_data_out", 32'(d1_data_out), 32'(q[0]));
        end
    endtask

    task automatic step(input logic we, input logic re, input logic [7:0] d);
        bit racc, wacc;
        write_en = we;
        read_en  = re;
        data_in  = d;
        racc = re && (m_count != 0);
        wacc = we && ((m_count != 16) || racc);
        @(posedge clk);
        #1;
        if (racc) m_dout = q.pop_front();
        if (wacc) q.push_back(d);
        m_count = m_count + int'(wacc) - int'(racc);
        if (we && !wacc) m_ovf = 1;
        if (re && !racc) m_udf = 1;
        write_en = 1'b0;
        read_en  = 1'b0;
        check_all();
    endtask

    task automatic do_rst(input logic we, input logic [7:0] d);
        rst      = 1'b1;
        write_en = we;
        data_in  = d;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        write_en = 1'b0;
        q.delete();
        m_count = 0;
        m_ovf   = 0;
        m_udf   = 0;
        m_dout  = 8'h00;
        check_all();
        chk("fwft_rst_data_out", 32'(d1_data_out), 32'h0);
    endtask

    initial begin
        do_rst(1'b0, 8'h00);

        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b0, 8'hAB);
        step(1'b1, 1'b1, 8'h55);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);

        step(1'b1, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00);

        step(1'b1, 1'b0, 8'h7E);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);

        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        do_rst(1'b1, 8'h99);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h44);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
